// File: rtl/iob_ptfloat2double_arb.sv
// Round-robin arbiter sharing one posit-to-double converter among N_REQ requesters.
// One conversion in flight; the result is held until the owning requester's response is accepted.

`ifndef EXP_MAX_W
`define EXP_MAX_W 12
`endif
`ifndef MAN_MAX_W
`define MAN_MAX_W 32
`endif
`ifndef FP_DP_DATA_W
`define FP_DP_DATA_W 64
`endif

module iob_ptfloat2double_arb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EW_W   = 4,
  parameter int unsigned N_REQ  = 4
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic                          cke_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  output logic [N_REQ-1:0]              req_ready_o,
  input  logic [N_REQ*`EXP_MAX_W-1:0]   req_exp_i,
  input  logic [N_REQ*`MAN_MAX_W-1:0]   req_man_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(N_REQ)-1:0]      rsp_id_o,
  output logic [`FP_DP_DATA_W-1:0]      rsp_fp_o,
  output logic                          conv_start_o,
  input  logic                          conv_done_i,
  output logic [`EXP_MAX_W-1:0]         conv_exp_o,
  output logic [`MAN_MAX_W-1:0]         conv_man_o,
  input  logic [`FP_DP_DATA_W-1:0]      conv_fp_i
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("N_REQ must be in 2..8");
  end
  if (DATA_W > `MAN_MAX_W || EW_W > `EXP_MAX_W) begin : g_bad_width
    $error("DATA_W/EW_W exceed the converter operand widths");
  end

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] owner_q;
  logic            start_q;
  logic [ID_W-1:0] win;
  logic            found;
  logic            grant;

  // (a + b) mod N_REQ for a < N_REQ, b <= N_REQ
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int unsigned b);
    logic [ID_W:0] s;
    s = {1'b0, a} + (ID_W+1)'(b);
    if (s >= (ID_W+1)'(N_REQ)) s = s - (ID_W+1)'(N_REQ);
    return s[ID_W-1:0];
  endfunction

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_valid_i[wrap_add(ptr_q, i)]) begin
        found = 1'b1;
        win   = wrap_add(ptr_q, i);
      end
    end
  end

  // Gated by reset and enable so no accept is ever seen while frozen or held in reset.
  assign grant = arst_n_i && cke_i && (state_q == IDLE) && found;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      req_ready_o[k] = grant && (win == ID_W'(k));
    end
  end

  assign conv_start_o = start_q && cke_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (conv_done_i) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      start_q     <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_fp_o    <= '0;
      conv_exp_o  <= '0;
      conv_man_o  <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      start_q <= grant;
      if (grant) begin
        ptr_q      <= wrap_add(win, 1);
        owner_q    <= win;
        conv_exp_o <= req_exp_i[int'(win)*`EXP_MAX_W +: `EXP_MAX_W];
        conv_man_o <= req_man_i[int'(win)*`MAN_MAX_W +: `MAN_MAX_W];
      end
      if (state_q == WAIT && conv_done_i) begin
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= owner_q;
        rsp_fp_o    <= conv_fp_i;
      end
      if (state_q == RESP && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iob_ptfloat2double_arb.sv
// Directed bench for iob_ptfloat2double_arb: cycle-level transaction model checked on every
// falling edge, plus hand-computed literal checks for the key scenarios.

`ifndef EXP_MAX_W
`define EXP_MAX_W 12
`endif
`ifndef MAN_MAX_W
`define MAN_MAX_W 32
`endif
`ifndef FP_DP_DATA_W
`define FP_DP_DATA_W 64
`endif

module tb_iob_ptfloat2double_arb;

  localparam int N_REQ = 4;
  localparam int EW    = `EXP_MAX_W;
  localparam int MW    = `MAN_MAX_W;
  localparam int FW    = `FP_DP_DATA_W;

  logic                clk_i = 1'b0;
  logic                arst_n_i;
  logic                cke_i;
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [N_REQ*EW-1:0] req_exp_i;
  logic [N_REQ*MW-1:0] req_man_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [1:0]          rsp_id_o;
  logic [FW-1:0]       rsp_fp_o;
  logic                conv_start_o;
  logic                conv_done_i;
  logic [EW-1:0]       conv_exp_o;
  logic [MW-1:0]       conv_man_o;
  logic [FW-1:0]       conv_fp_i;

  iob_ptfloat2double_arb #(
    .DATA_W(32),
    .EW_W  (4),
    .N_REQ (N_REQ)
  ) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_exp_i   (req_exp_i),
    .req_man_i   (req_man_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_fp_o    (rsp_fp_o),
    .conv_start_o(conv_start_o),
    .conv_done_i (conv_done_i),
    .conv_exp_o  (conv_exp_o),
    .conv_man_o  (conv_man_o),
    .conv_fp_i   (conv_fp_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Transaction model: busy from grant until response accepted; m_age counts enabled cycles
  // since the grant (1 = start cycle, >=2 = waiting for the converter).
  bit             m_busy = 1'b0;
  bit             m_got  = 1'b0;
  int             m_age  = 0;
  int             m_ptr  = 0;
  int             m_id   = 0;
  logic [EW-1:0]  m_exp  = '0;
  logic [MW-1:0]  m_man  = '0;
  logic [FW-1:0]  m_fp   = '0;
  int             glog[$];
  int             w_m;
  logic [3:0]     er_m;
  bit             conv_auto = 1'b0;

  function automatic int pick(input logic [N_REQ-1:0] v, input int p);
    for (int i = 0; i < N_REQ; i++) begin
      if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
    end
    return -1;
  endfunction

  always @(negedge clk_i) begin
    if (!arst_n_i) begin
      m_busy = 1'b0;
      m_got  = 1'b0;
      m_age  = 0;
      m_ptr  = 0;
      check("rst_ready", 64'(req_ready_o), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_start", 64'(conv_start_o), 64'd0);
    end else begin
      w_m  = pick(req_valid_i, m_ptr);
      er_m = (cke_i && !m_busy && w_m >= 0) ? 4'(1 << w_m) : 4'd0;
      check("m_req_ready", 64'(req_ready_o), 64'(er_m));
      check("m_conv_start", 64'(conv_start_o), 64'(cke_i && m_busy && !m_got && m_age == 1));
      check("m_rsp_valid", 64'(rsp_valid_o), 64'(m_got));
      if (m_got) begin
        check("m_rsp_id", 64'(rsp_id_o), 64'(m_id));
        check("m_rsp_fp", rsp_fp_o, m_fp);
      end
      if (m_busy) begin
        check("m_conv_exp", 64'(conv_exp_o), 64'(m_exp));
        check("m_conv_man", 64'(conv_man_o), 64'(m_man));
      end
      if (cke_i) begin
        if (m_got) begin
          if (rsp_ready_i) begin
            m_busy = 1'b0;
            m_got  = 1'b0;
          end
        end else if (m_busy) begin
          if (m_age >= 2 && conv_done_i) begin
            m_got = 1'b1;
            m_fp  = conv_fp_i;
          end
          m_age++;
        end else if (w_m >= 0) begin
          glog.push_back(w_m);
          m_busy = 1'b1;
          m_age  = 1;
          m_id   = w_m;
          m_exp  = req_exp_i[w_m*EW +: EW];
          m_man  = req_man_i[w_m*MW +: MW];
          m_ptr  = (w_m + 1) % N_REQ;
        end
      end
    end
  end

  // Converter stand-in: answers two cycles after a start pulse.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (conv_auto && conv_start_o) begin
        repeat (2) begin
          @(posedge clk_i);
          #1;
        end
        conv_fp_i   = {20'h3FF00, conv_exp_o, conv_man_o};
        conv_done_i = 1'b1;
        @(posedge clk_i);
        #1;
        conv_done_i = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (m_busy && n < lim) begin
      step();
      n++;
    end
    check("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic wait_grants(input int cnt, input int lim);
    int n = 0;
    while (glog.size() < cnt && n < lim) begin
      step();
      n++;
    end
    check("grant_timeout", 64'(glog.size() >= cnt), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    arst_n_i = 1'b0;
    @(negedge clk_i);
    #2;
    arst_n_i = 1'b1;
    step();
  endtask

  int exp_fair[5] = '{0, 1, 2, 3, 0};

  initial begin
    arst_n_i    = 1'b0;
    cke_i       = 1'b1;
    req_valid_i = 4'b1111;
    rsp_ready_i = 1'b0;
    conv_done_i = 1'b0;
    conv_fp_i   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_exp_i[k*EW +: EW] = EW'(k + 5);
      req_man_i[k*MW +: MW] = MW'(32'h1000_0000 * (k + 1) + k);
    end
    #2;
    check("reset_ready", 64'(req_ready_o), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_rsp_id", 64'(rsp_id_o), 64'd0);
    check("reset_rsp_fp", rsp_fp_o, 64'd0);
    check("reset_start", 64'(conv_start_o), 64'd0);
    check("reset_conv_exp", 64'(conv_exp_o), 64'd0);
    check("reset_conv_man", 64'(conv_man_o), 64'd0);
    req_valid_i = 4'b0000;
    #10;
    arst_n_i = 1'b1;
    step();

    // Single request from requester 0
    req_exp_i[0 +: EW] = '0;
    req_man_i[0 +: MW] = 32'h8000_0000;
    req_valid_i = 4'b0001;
    #1;
    check("single_ready", 64'(req_ready_o), 64'h1);
    step();
    req_valid_i = 4'b0000;
    check("single_start", 64'(conv_start_o), 64'd1);
    check("single_ready_off", 64'(req_ready_o), 64'd0);
    check("single_man", 64'(conv_man_o), 64'h8000_0000);
    step();
    check("single_start_off", 64'(conv_start_o), 64'd0);
    conv_fp_i   = 64'h3FF0_0000_0000_0000;
    conv_done_i = 1'b1;
    step();
    conv_done_i = 1'b0;
    conv_fp_i   = 64'h0;
    check("single_rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("single_rsp_id", 64'(rsp_id_o), 64'd0);
    check("single_rsp_fp", rsp_fp_o, 64'h3FF0_0000_0000_0000);

    // Backpressure while another requester waits
    req_valid_i = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("bp_rsp_fp", rsp_fp_o, 64'h3FF0_0000_0000_0000);
      check("bp_ready", 64'(req_ready_o), 64'd0);
      check("bp_start", 64'(conv_start_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    step();
    check("bp_released", 64'(rsp_valid_o), 64'd0);
    check("bp_next_grant", 64'(req_ready_o), 64'h2);
    conv_auto = 1'b1;
    step();
    req_valid_i = 4'b0000;
    wait_idle(100);

    // Fairness from ptr = 0
    do_reset();
    glog.delete();
    req_valid_i = 4'b1111;
    wait_grants(5, 300);
    req_valid_i = 4'b0000;
    wait_idle(100);
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) check("fair_order", 64'(glog[i]), 64'(exp_fair[i]));
    end

    // Wrap: move ptr to 3, then requesters 0 and 3
    do_reset();
    glog.delete();
    req_valid_i = 4'b0100;
    wait_grants(1, 50);
    req_valid_i = 4'b0000;
    wait_idle(100);
    glog.delete();
    req_valid_i = 4'b1001;
    wait_grants(2, 100);
    req_valid_i = 4'b0000;
    wait_idle(100);
    if (glog.size() >= 2) begin
      check("wrap_first", 64'(glog[0]), 64'd3);
      check("wrap_second", 64'(glog[1]), 64'd0);
    end

    // Reset in the middle of a conversion
    conv_auto = 1'b0;
    req_exp_i[0 +: EW] = 12'h00A;
    req_valid_i = 4'b0001;
    step();
    req_valid_i = 4'b0000;
    step();
    #1;
    arst_n_i    = 1'b0;
    req_valid_i = 4'b0001;
    #1;
    check("midrst_ready", 64'(req_ready_o), 64'd0);
    check("midrst_exp", 64'(conv_exp_o), 64'd0);
    check("midrst_man", 64'(conv_man_o), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("midrst_rsp_fp", rsp_fp_o, 64'd0);
    @(negedge clk_i);
    #2;
    arst_n_i    = 1'b1;
    req_valid_i = 4'b0000;
    conv_fp_i   = 64'hDEAD_BEEF_0000_0001;
    conv_done_i = 1'b1;
    step();
    step();
    conv_done_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_rsp", 64'(rsp_valid_o), 64'd0);
    end

    // Clock enable low while waiting on the converter
    rsp_ready_i = 1'b0;
    req_valid_i = 4'b0001;
    step();
    req_valid_i = 4'b0000;
    step();
    cke_i       = 1'b0;
    conv_done_i = 1'b1;
    conv_fp_i   = 64'h1111_1111_1111_1111;
    req_valid_i = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      check("cke_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("cke_start", 64'(conv_start_o), 64'd0);
      check("cke_ready", 64'(req_ready_o), 64'd0);
    end
    cke_i       = 1'b1;
    conv_done_i = 1'b0;
    step();
    check("cke_still_wait", 64'(rsp_valid_o), 64'd0);
    conv_done_i = 1'b1;
    conv_fp_i   = 64'h4009_21FB_5444_2D18;
    step();
    conv_done_i = 1'b0;
    check("cke_rsp_valid_on", 64'(rsp_valid_o), 64'd1);
    check("cke_rsp_id", 64'(rsp_id_o), 64'd0);
    check("cke_rsp_fp", rsp_fp_o, 64'h4009_21FB_5444_2D18);
    rsp_ready_i = 1'b1;
    step();
    conv_auto = 1'b1;
    step();
    req_valid_i = 4'b0000;
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/iob_ptfloat2double_arb.md
IOB_PTFLOAT2DOUBLE_ARB -- requirements
Module: iob_ptfloat2double_arb

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, posit word width passed to the shared converter; EW_W, default 4, exponent-width field width; N_REQ, default 4, number of requesters (2..8).
REQ-002 Ports SHALL be, clock and reset first:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable
- req_valid_i  in  N_REQ  per-requester request valid
- req_ready_o  out  N_REQ  per-requester accept, one-hot or zero
- req_exp_i  in  N_REQ*`EXP_MAX_W  packed exponents, requester k at slice k
- req_man_i  in  N_REQ*`MAN_MAX_W  packed mantissas, requester k at slice k
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result accept
- rsp_id_o  out  $clog2(N_REQ)  requester index owning the result
- rsp_fp_o  out  `FP_DP_DATA_W  IEEE-754 double result
- conv_start_o  out  1  start pulse to the shared converter
- conv_done_i  in  1  converter done
- conv_exp_o  out  `EXP_MAX_W  operand exponent to the converter
- conv_man_o  out  `MAN_MAX_W  operand mantissa to the converter
- conv_fp_i  in  `FP_DP_DATA_W  converter result
REQ-003 Clock is single (clk_i); reset is asynchronous, active-low (arst_n_i); both are fixed.

Function
REQ-004 The block SHALL share one converter among N_REQ requesters, with one conversion in flight at a time.
REQ-005 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-006 IDLE: if any req_valid_i is high, grant the round-robin winner: req_ready_o[winner]=1 for that cycle only, latch its exp/man and index, go to START.
REQ-007 Round-robin: search begins at index ptr; after a grant ptr = (winner+1) mod N_REQ, wrapping N_REQ-1 -> 0.
REQ-008 START: conv_start_o=1 for exactly one cycle, go to WAIT.
REQ-009 WAIT: hold conv_exp_o/conv_man_o stable; on conv_done_i=1 latch conv_fp_i into rsp_fp_o, go to RESP.
REQ-010 RESP: rsp_valid_o=1 with rsp_id_o/rsp_fp_o stable until rsp_ready_i=1; on that cycle go to IDLE.
REQ-011 conv_done_i outside WAIT SHALL be ignored.
REQ-012 Minimum latency SHALL be grant at cycle 0, conv_start_o at cycle 1, rsp_valid_o at 1 cycle after conv_done_i; back-to-back grants spaced at least 1 cycle after rsp handshake.
REQ-013 req_ready_o SHALL be zero in START, WAIT, RESP; requesters hold req_valid_i and operands until ready.
REQ-014 Deasserting req_valid_i before grant SHALL withdraw the request with no side effect.
REQ-015 cke_i=0 SHALL freeze state, ptr, and registered outputs; req_ready_o and conv_start_o SHALL be 0 while cke_i=0.
REQ-016 All outputs SHALL be registered, except req_ready_o, which may be combinational from state, ptr, and req_valid_i.

Reset
REQ-017 arst_n_i=0 SHALL immediately force state=IDLE, ptr=0, req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_fp_o=0, conv_start_o=0, conv_exp_o=0, conv_man_o=0.
REQ-018 Reset during WAIT or RESP SHALL drop the in-flight result with no response issued; a later conv_done_i is ignored.

Verification
REQ-019 Single request: req_valid_i=4'b0001, exp=0, man=32'h80000000 -> req_ready_o=4'b0001 for 1 cycle, conv_start_o pulses next cycle, then rsp_id_o=0, rsp_fp_o=conv_fp_i captured, rsp_valid_o held until rsp_ready_i.
REQ-020 Fairness: req_valid_i=4'b1111 held, rsp_ready_i=1 -> grant order 0,1,2,3,0; each index granted once per 4 grants.
REQ-021 Wrap: ptr=3 with requests from 0 and 3 -> grant 3 then 0.
REQ-022 Backpressure: rsp_ready_i=0 for 10 cycles in RESP -> rsp_* stable, no new grant, conv_start_o=0.
REQ-023 Async reset asserted mid-WAIT -> all outputs 0 within the same cycle; conv_done_i afterwards produces no rsp_valid_o.
REQ-024 cke_i=0 for 5 cycles in WAIT while conv_done_i pulses -> no state change; conv_done_i re-asserted with cke_i=1 -> normal response.
